// File: rtl/timer_sequencer_pkg.sv
// Shared types for the timer sequencer: FSM states, latched config
// and the config legality check used on the host handshake.
package timer_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RELOAD
  } tseq_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [2:0]       step;
    logic             up;
    logic             oneshot;
  } tseq_cfg_t;

  // A down count must land exactly on 0, so P has to divide by step+1
  function automatic logic cfg_bad(input tseq_cfg_t c);
    logic [CNT_W-1:0] p;
    logic             rem;
    p = c.period;
    unique case (c.step)
      3'd0: rem = 1'b0;
      3'd1: rem = p[0];
      3'd2: rem = (p % 32'd3) != '0;
      3'd3: rem = |p[1:0];
      3'd4: rem = (p % 32'd5) != '0;
      3'd5: rem = (p % 32'd6) != '0;
      3'd6: rem = (p % 32'd7) != '0;
      3'd7: rem = |p[2:0];
    endcase
    return (p == '0) || (!c.up && rem);
  endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Host config handshake for the timer sequencer.
// master = host register side, slave = sequencer.
interface timer_sequencer_if;
  import timer_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [2:0]       cfg_step;
  logic             cfg_up;
  logic             cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_step,
    output cfg_up,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_step,
    input  cfg_up,
    input  cfg_oneshot,
    output cfg_ready
  );

endinterface

// File: rtl/timer_sequencer.sv
// Control FSM driving the external up/down saturating counter:
// one-shot / periodic timing, expiry count and sticky interrupt.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int EXP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  timer_sequencer_if.slave cfg,
  input  logic             stop,
  input  logic             irq_ack,
  input  logic             cnt_timer_event,
  output logic             cnt_enable,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_din,
  output logic [CNT_W-1:0] cnt_sat_count,
  output logic [2:0]       cnt_mode,
  output logic             cnt_up_down,
  output logic             busy,
  output logic             cfg_err,
  output logic             irq,
  output logic             overrun,
  output logic [EXP_W-1:0] exp_count
);

  tseq_state_e state;
  tseq_state_e state_n;
  tseq_cfg_t   cfg_q;
  tseq_cfg_t   cfg_in;
  logic        bad;
  logic        accept;
  logic        reject;
  logic        expire;

  assign cfg_in = '{
    period:  cfg.cfg_period,
    step:    cfg.cfg_step,
    up:      cfg.cfg_up,
    oneshot: cfg.cfg_oneshot
  };

  assign bad    = cfg_bad(cfg_in);
  assign accept = (state == IDLE) && cfg.cfg_valid && !bad;
  assign reject = (state == IDLE) && cfg.cfg_valid && bad;
  assign expire = (state == RUN) && cnt_timer_event;

  assign cnt_din       = cfg_q.up ? '0 : cfg_q.period;
  assign cnt_sat_count = cfg_q.period;
  assign cnt_mode      = cfg_q.step;
  assign cnt_up_down   = cfg_q.up;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept) state_n = LOAD;
      LOAD:   state_n = stop ? IDLE : RUN;
      RUN: begin
        if (stop)        state_n = IDLE;
        else if (expire) state_n = cfg_q.oneshot ? IDLE : RELOAD;
      end
      RELOAD: state_n = stop ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cfg_q         <= '0;
      cfg.cfg_ready <= 1'b1;
      busy          <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_enable    <= 1'b0;
      cfg_err       <= 1'b0;
      irq           <= 1'b0;
      overrun       <= 1'b0;
      exp_count     <= '0;
    end else begin
      state         <= state_n;
      cfg.cfg_ready <= state_n == IDLE;
      busy          <= state_n != IDLE;
      cnt_load      <= (state_n == LOAD) || (state_n == RELOAD);
      cnt_enable    <= state_n == RUN;
      cfg_err       <= reject;
      if (accept) cfg_q <= cfg_in;
      if (accept)
        exp_count <= '0;
      else if (expire && (exp_count != '1))
        exp_count <= exp_count + 1'b1;
      // A new expiry beats a simultaneous ack
      if (expire) begin
        irq <= 1'b1;
        if (!irq_ack) overrun <= overrun | irq;
      end else if (irq_ack) begin
        irq     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
